// File: rtl/ysyx_25040129_regfile_sb_if.sv
// ysyx_25040129_regfile_sb_if: write/read/issue bundle between the pipeline (master) and the register file (slave)
interface ysyx_25040129_regfile_sb_if #(
  parameter int XLEN = 32,
  parameter int AW   = 4
);
  localparam int NREG = 2 ** AW;
  logic                 wen0;
  logic [AW-1:0]        waddr0;
  logic [XLEN-1:0]      wdata0;
  logic                 wen1;
  logic [AW-1:0]        waddr1;
  logic [XLEN-1:0]      wdata1;
  logic [AW-1:0]        raddr0;
  logic [AW-1:0]        raddr1;
  logic [XLEN-1:0]      rdata0;
  logic [XLEN-1:0]      rdata1;
  logic                 iss_valid;
  logic [AW-1:0]        iss_rd;
  logic                 rbusy0;
  logic                 rbusy1;
  logic [NREG-1:0]      busy_vec;
  logic [NREG*XLEN-1:0] regs_out;
  modport master (
    output wen0, waddr0, wdata0, wen1, waddr1, wdata1, raddr0, raddr1, iss_valid, iss_rd,
    input  rdata0, rdata1, rbusy0, rbusy1, busy_vec, regs_out
  );
  modport slave (
    input  wen0, waddr0, wdata0, wen1, waddr1, wdata1, raddr0, raddr1, iss_valid, iss_rd,
    output rdata0, rdata1, rbusy0, rbusy1, busy_vec, regs_out
  );
endinterface

// File: rtl/ysyx_25040129_regfile_sb.sv
// ysyx_25040129_regfile_sb: 2W/2R register file with issue scoreboard; define YSYX_25040129_RF_BYPASS_EN for same-cycle forwarding
module ysyx_25040129_regfile_sb #(
  parameter int XLEN = 32,
  parameter int AW   = 4
) (
  input logic clk,
  input logic rst,
  ysyx_25040129_regfile_sb_if.slave rf
);
  localparam int NREG = 2 ** AW;
  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy_q, busy_d, hit0, hit1, iss_hit;
  genvar i;
  // Register 0 is excluded from every decode, so it stays at its reset value forever
  for (i = 0; i < NREG; i++) begin : g_reg
    assign hit0[i]    = (i != 0) && rf.wen0 && (rf.waddr0 == AW'(i));
    assign hit1[i]    = (i != 0) && rf.wen1 && (rf.waddr1 == AW'(i));
    assign iss_hit[i] = (i != 0) && rf.iss_valid && (rf.iss_rd == AW'(i));
    assign regs_d[i]  = hit1[i] ? rf.wdata1 : hit0[i] ? rf.wdata0 : regs_q[i];
    assign busy_d[i]  = iss_hit[i] || (busy_q[i] && !hit0[i] && !hit1[i]);
    assign rf.regs_out[i*XLEN +: XLEN] = regs_q[i];
  end
  always_ff @(posedge clk) begin
    for (int k = 0; k < NREG; k++) regs_q[k] <= rst ? '0 : regs_d[k];
    busy_q <= rst ? '0 : busy_d;
  end
  assign rf.busy_vec = busy_q;
`ifdef YSYX_25040129_RF_BYPASS_EN
  logic [NREG-1:0] wr;
  assign wr        = hit0 | hit1;
  assign rf.rdata0 = hit1[rf.raddr0] ? rf.wdata1 : hit0[rf.raddr0] ? rf.wdata0 : regs_q[rf.raddr0];
  assign rf.rdata1 = hit1[rf.raddr1] ? rf.wdata1 : hit0[rf.raddr1] ? rf.wdata0 : regs_q[rf.raddr1];
  assign rf.rbusy0 = busy_q[rf.raddr0] && !(wr[rf.raddr0] && !iss_hit[rf.raddr0]);
  assign rf.rbusy1 = busy_q[rf.raddr1] && !(wr[rf.raddr1] && !iss_hit[rf.raddr1]);
`else
  assign rf.rdata0 = regs_q[rf.raddr0];
  assign rf.rdata1 = regs_q[rf.raddr1];
  assign rf.rbusy0 = busy_q[rf.raddr0];
  assign rf.rbusy1 = busy_q[rf.raddr1];
`endif
endmodule

// File: doc/ysyx_25040129_regfile_sb.md
YSYX_25040129_REGFILE_SB -- requirements
Module: ysyx_25040129_regfile_sb

Interface
REQ-001 SHALL provide parameter XLEN, default 32, data width of each register.
REQ-002 SHALL provide parameter AW, default 4, address width; register count NREG = 2**AW (16 = RV32E, AW=5 gives 32).
REQ-003 clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 wen0/waddr0/wdata0  in  1/AW/XLEN  write port 0 (ALU writeback).
REQ-006 wen1/waddr1/wdata1  in  1/AW/XLEN  write port 1 (LSU writeback).
REQ-007 raddr0/raddr1  in  AW each  read addresses.
REQ-008 rdata0/rdata1  out  XLEN each  read data, combinational from address.
REQ-009 iss_valid/iss_rd  in  1/AW  issue of an instruction that will later write iss_rd.
REQ-010 rbusy0/rbusy1  out  1 each  scoreboard pending bit of raddr0/raddr1.
REQ-011 busy_vec  out  NREG  full scoreboard, bit i = register i pending.
REQ-012 regs_out  out  NREG*XLEN  flattened register contents, register i at bits [i*XLEN +: XLEN], for difftest.

Function
REQ-013 Register 0 SHALL always read 0, ignore writes, and never be marked busy (iss_rd=0 ignored).
REQ-014 On posedge with wenN=1 and waddrN!=0, register waddrN SHALL take wdataN; visible on rdata the following cycle.
REQ-015 Both ports writing the same nonzero address in one cycle: port 1 data SHALL win; distinct addresses SHALL both commit.
REQ-016 Busy bit of waddrN SHALL clear on posedge when wenN=1 (either port).
REQ-017 Busy bit of iss_rd SHALL set on posedge when iss_valid=1.
REQ-018 Same register set by issue and cleared by write in one cycle: set SHALL win (new producer outstanding).
REQ-019 Issue to an already-busy register SHALL leave it busy (no counting; one producer in flight per register).
REQ-020 rbusyN SHALL equal busy_vec[raddrN] as defined by the configuration below; rbusyN=0 when raddrN=0.
REQ-021 Read ports SHALL be independent; both may address the same register.
REQ-022 regs_out SHALL reflect stored state only (never bypassed), bits [XLEN-1:0] always 0.

Reset
REQ-023 While rst=1 at posedge, all registers SHALL become 0 and busy_vec SHALL become 0; writes and issues that cycle SHALL be discarded.
REQ-024 Out of reset: rdata0=rdata1=0, rbusy0=rbusy1=0, busy_vec=0, regs_out=0.
REQ-025 Reset asserted mid-operation SHALL clear all pending busy bits regardless of in-flight writes.

Configuration
REQ-026 Macro YSYX_25040129_RF_BYPASS_EN SHALL select same-cycle forwarding.
REQ-027 Defined: rdataN SHALL return wdata of a same-cycle write to nonzero raddrN (port 1 over port 0, over stored value); rbusyN SHALL be 0 if that register is being written this cycle and not simultaneously issued.
REQ-028 Undefined: rdataN and rbusyN SHALL reflect stored state only; write data visible one cycle later.
REQ-029 Sequential state and regs_out SHALL be identical in both builds.

Verification
REQ-030 rst 1 cycle, then read all addresses -> all rdata 0, busy_vec=0x0000, regs_out=0.
REQ-031 wen0=1,waddr0=5,wdata0=0xDEADBEEF, next cycle raddr0=5 -> rdata0=0xDEADBEEF; same write to addr 0 -> rdata 0.
REQ-032 wen0 addr 3 data 0x11 and wen1 addr 3 data 0x22 same cycle -> reg3=0x22; addrs 3/4 -> reg3=0x11, reg4=0x22.
REQ-033 iss_rd=7 -> busy_vec[7]=1, rbusy0=1 at raddr0=7; next wen1 addr 7 with iss_rd=7 same cycle -> busy stays 1; later wen0 addr 7 alone -> busy 0.
REQ-034 Bypass build: wen0 addr 9 data 0x1234 with raddr1=9 same cycle -> rdata1=0x1234, rbusy1=0; non-bypass build -> old value, stored busy.
REQ-035 Issue rd=2, write reg2=0x55, assert rst one cycle -> reg2=0, busy_vec=0.
